fog_sqwave_demod: RTL

- Parametrised next-generation square-wave modulation and demodulation engine for the FOG loop. Runs on CLOCK_ADC.
- Generates the bias-modulation square wave, with H/L amplitudes and polarity, for the phase-ramp path.
- Samples the parallel ADC in a programmable window inside each half-period and averages over 2^avg_sel samples.
- Outputs a signed, offset-corrected, saturated error word once per full modulation period, with a valid strobe and a window-fault flag.

---
 rtl/fog_sqwave_demod.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/fog_sqwave_demod.sv
// Square-wave bias modulator and synchronous demodulator for the FOG loop; o_err lands 2 cycles after the last L-half sample.
// No backpressure: the ADC is consumed every cycle and o_err_valid is a one-cycle strobe per modulation period.
module fog_sqwave_demod #(
    parameter int ADC_W          = 14,
    parameter int DW             = 32,
    parameter int CNT_W          = 16,
    parameter int MAX_AVG        = 10,
    parameter int ADC_OFFSET_BIN = 1
) (
    input  logic             CLOCK_ADC,
    input  logic             RST,
    input  logic             i_en,
    input  logic [ADC_W-1:0] i_adc,
    input  logic [CNT_W-1:0] i_freq_cnt,
    input  logic [CNT_W-1:0] i_wait_cnt,
    input  logic [3:0]       i_avg_sel,
    input  logic [DW-1:0]    i_amp_H,
    input  logic [DW-1:0]    i_amp_L,
    input  logic             i_polarity,
    input  logic [DW-1:0]    i_err_offset,
    output logic [DW-1:0]    o_mod,
    output logic             o_phase,
    output logic [DW-1:0]    o_err,
    output logic             o_err_valid,
    output logic             o_win_fault
);

    localparam int AW = ADC_W + MAX_AVG + 1;
    localparam int NW = MAX_AVG + 1;
    localparam int SW = AW + 1;
    localparam int XW = ((SW > DW) ? SW : DW) + 1;
    localparam logic [3:0] AVG_MAX = 4'(MAX_AVG);
    localparam logic signed [XW-1:0] SAT_HI = {{(XW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_LO = {{(XW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] freq_q;
    logic [CNT_W-1:0] wait_q;
    logic [3:0]       avg_q;
    logic [DW-1:0]    amp_h_q;
    logic [DW-1:0]    amp_l_q;
    logic             pol_q;

    logic             latch_now;
    logic [CNT_W-1:0] freq_c;
    logic [CNT_W-1:0] wait_c;
    logic [3:0]       avg_c;
    logic [DW-1:0]    amp_h_c;
    logic [DW-1:0]    amp_l_c;
    logic             pol_c;

    // The first H cycle already runs on the freshly presented configuration.
    always_comb begin
        latch_now = i_en && (cnt == '0) && !o_phase;
        freq_c    = freq_q;
        wait_c    = wait_q;
        avg_c     = avg_q;
        amp_h_c   = amp_h_q;
        amp_l_c   = amp_l_q;
        pol_c     = pol_q;
        if (latch_now) begin
            freq_c  = (i_freq_cnt < CNT_W'(2)) ? CNT_W'(2) : i_freq_cnt;
            wait_c  = i_wait_cnt;
            avg_c   = (i_avg_sel > AVG_MAX) ? AVG_MAX : i_avg_sel;
            amp_h_c = i_amp_H;
            amp_l_c = i_amp_L;
            pol_c   = i_polarity;
        end
    end

    logic             last_cnt;
    logic             phase_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [DW-1:0]    mod_nxt;

    always_comb begin
        last_cnt  = (cnt == freq_c - CNT_W'(1));
        cnt_nxt   = last_cnt ? '0 : cnt + CNT_W'(1);
        phase_nxt = o_phase ^ last_cnt;
        mod_nxt   = (phase_nxt ^ pol_c) ? (DW'(0) - amp_l_c) : amp_h_c;
    end

    logic signed [ADC_W-1:0] adc_s;
    logic signed [AW-1:0]    acc;
    logic signed [AW-1:0]    acc_base;
    logic signed [AW-1:0]    acc_nxt;
    logic signed [AW-1:0]    sum_h;
    logic [NW-1:0]           nsamp;
    logic [NW-1:0]           nsamp_base;
    logic [NW-1:0]           nsamp_nxt;
    logic [NW-1:0]           need;
    logic                    take;
    logic                    short_nxt;
    logic                    short_h;

    always_comb begin
        if (ADC_OFFSET_BIN != 0) begin
            adc_s = {~i_adc[ADC_W-1], i_adc[ADC_W-2:0]};
        end else begin
            adc_s = i_adc;
        end
        need       = NW'(1) << avg_c;
        acc_base   = (cnt == '0) ? '0 : acc;
        nsamp_base = (cnt == '0) ? '0 : nsamp;
        take       = i_en && (wait_c <= cnt) && (nsamp_base < need);
        acc_nxt    = take ? (acc_base + AW'(adc_s)) : acc_base;
        nsamp_nxt  = nsamp_base + NW'(take);
        short_nxt  = (nsamp_nxt < need);
    end

    logic signed [AW-1:0] avg_h;
    logic signed [AW-1:0] avg_l;
    logic signed [SW-1:0] diff_nxt;
    logic signed [SW-1:0] diff_q;
    logic                 snap_vld;
    logic                 snap_fault;

    // Demodulation sign follows the raw phase; polarity only flips o_mod.
    always_comb begin
        avg_h    = sum_h >>> avg_c;
        avg_l    = acc_nxt >>> avg_c;
        diff_nxt = SW'(avg_h) - SW'(avg_l);
    end

    always_ff @(posedge CLOCK_ADC or posedge RST) begin
        if (RST) begin
            cnt        <= '0;
            o_phase    <= 1'b0;
            o_mod      <= '0;
            freq_q     <= CNT_W'(2);
            wait_q     <= '0;
            avg_q      <= '0;
            amp_h_q    <= '0;
            amp_l_q    <= '0;
            pol_q      <= 1'b0;
            acc        <= '0;
            nsamp      <= '0;
            sum_h      <= '0;
            short_h    <= 1'b0;
            diff_q     <= '0;
            snap_fault <= 1'b0;
            snap_vld   <= 1'b0;
        end else if (!i_en) begin
            cnt      <= '0;
            o_phase  <= 1'b0;
            o_mod    <= '0;
            acc      <= '0;
            nsamp    <= '0;
            snap_vld <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            o_phase  <= phase_nxt;
            o_mod    <= mod_nxt;
            acc      <= acc_nxt;
            nsamp    <= nsamp_nxt;
            snap_vld <= last_cnt && o_phase;
            if (latch_now) begin
                freq_q  <= freq_c;
                wait_q  <= wait_c;
                avg_q   <= avg_c;
                amp_h_q <= amp_h_c;
                amp_l_q <= amp_l_c;
                pol_q   <= pol_c;
            end
            if (last_cnt && !o_phase) begin
                sum_h   <= acc_nxt;
                short_h <= short_nxt;
            end
            if (last_cnt && o_phase) begin
                diff_q     <= diff_nxt;
                snap_fault <= short_h | short_nxt;
            end
        end
    end

    logic signed [XW-1:0] err_full;
    logic [DW-1:0]        err_sat;

    always_comb begin
        err_full = XW'(diff_q) - XW'($signed(i_err_offset));
        if (err_full > SAT_HI) begin
            err_sat = {1'b0, {(DW-1){1'b1}}};
        end else if (err_full < SAT_LO) begin
            err_sat = {1'b1, {(DW-1){1'b0}}};
        end else begin
            err_sat = err_full[DW-1:0];
        end
    end

    // A snapshot taken while enabled always completes, even if i_en drops right after.
    always_ff @(posedge CLOCK_ADC or posedge RST) begin
        if (RST) begin
            o_err       <= '0;
            o_err_valid <= 1'b0;
            o_win_fault <= 1'b0;
        end else begin
            o_err_valid <= snap_vld;
            if (snap_vld) begin
                o_err       <= err_sat;
                o_win_fault <= snap_fault;
            end
        end
    end

endmodule
